// File: rtl/ksort_pkg.sv
// Shared types and width helpers for the k_sort result path.
package ksort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a rank index into a K-entry array (at least one bit).
  function automatic int unsigned rank_w(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Width of an entry count that can represent 0..K.
  function automatic int unsigned cnt_w(input int unsigned k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/ksort_drain.sv
// Snapshots the k_sort value/index arrays on start and streams them out rank 0 first.
// Optional KSORT_DRAIN_CLEAR_EN adds a clear_reg pulse on the cycle after start is taken.
module ksort_drain
  import ksort_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned K     = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [cnt_w(K)-1:0]   count,
  input  logic [WIDTH-1:0]      in_val [K],
  input  logic [WIDTH-1:0]      in_idx [K],
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [WIDTH-1:0]      out_index,
  output logic [rank_w(K)-1:0]  out_rank,
  output logic                  out_last,
`ifdef KSORT_DRAIN_CLEAR_EN
  output logic                  clear_reg,
`endif
  output logic                  done
);

  localparam int unsigned RW = rank_w(K);
  localparam int unsigned CW = cnt_w(K);

  state_e           state_q, state_d;
  logic [RW-1:0]    rank_q, rank_d;
  logic [CW-1:0]    n_q, n_d;
  logic [WIDTH-1:0] snap_val_q [K];
  logic [WIDTH-1:0] snap_idx_q [K];

  logic             accept_c;
  logic [WIDTH-1:0] data_d, index_d;
  logic             last_d;

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rank_q  <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      rank_q  <= rank_d;
      n_q     <= n_d;
    end
  end

  // Snapshot is written only on an accepted start, so it stays frozen for the drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(K); i++) begin
        snap_val_q[i] <= '0;
        snap_idx_q[i] <= '0;
      end
    end else if (accept_c) begin
      snap_val_q <= in_val;
      snap_idx_q <= in_idx;
    end
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    rank_d   = rank_q;
    n_d      = n_q;
    accept_c = 1'b0;
    data_d   = '0;
    index_d  = '0;
    last_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          n_d      = (count > CW'(K)) ? CW'(K) : count;
          rank_d   = '0;
          state_d  = (n_d != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (CW'(rank_q) == n_q - CW'(1)) begin
            state_d = DONE;
          end else begin
            rank_d = rank_q + RW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // On the start cycle the snapshot is not loaded yet, so bypass from the inputs
    if (state_d == SEND) begin
      if (accept_c) begin
        data_d  = in_val[0];
        index_d = in_idx[0];
      end else begin
        data_d  = snap_val_q[rank_d];
        index_d = snap_idx_q[rank_d];
      end
      last_d = (CW'(rank_d) == n_d - CW'(1));
    end
  end

  // Registered stream and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_rank  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == SEND);
      out_data  <= data_d;
      out_index <= index_d;
      out_rank  <= (state_d == SEND) ? rank_d : '0;
      out_last  <= last_d;
      done      <= (state_d == DONE);
    end
  end

`ifdef KSORT_DRAIN_CLEAR_EN
  // Release the sorter once its contents are held in the snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_reg <= 1'b0;
    end else begin
      clear_reg <= accept_c;
    end
  end
`else
  // Sorter clearing is owned by the controller in this build.
`endif

endmodule

// File: tb/tb_ksort_drain.sv
// Directed bench for ksort_drain with K=4, WIDTH=8; define KSORT_DRAIN_CLEAR_EN to cover clear_reg.
module tb_ksort_drain;

  localparam int unsigned W  = 8;
  localparam int unsigned KK = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   count;
  logic [W-1:0] in_val [KK];
  logic [W-1:0] in_idx [KK];
  logic         out_ready;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [W-1:0] out_index;
  logic [1:0]   out_rank;
  logic         out_last;
  logic         done;
`ifdef KSORT_DRAIN_CLEAR_EN
  logic         clear_reg;
`endif

  logic [W-1:0] ev [KK];
  logic [W-1:0] ei [KK];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ksort_drain #(.WIDTH(W), .K(KK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .count    (count),
    .in_val   (in_val),
    .in_idx   (in_idx),
    .out_ready(out_ready),
    .busy     (busy),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_index(out_index),
    .out_rank (out_rank),
    .out_last (out_last),
`ifdef KSORT_DRAIN_CLEAR_EN
    .clear_reg(clear_reg),
`endif
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_beat(input string tag, input int r, input logic last);
    check($sformatf("%s r%0d valid", tag, r), 32'(out_valid), 32'd1);
    check($sformatf("%s r%0d data",  tag, r), 32'(out_data),  32'(ev[r]));
    check($sformatf("%s r%0d index", tag, r), 32'(out_index), 32'(ei[r]));
    check($sformatf("%s r%0d rank",  tag, r), 32'(out_rank),  32'(r));
    check($sformatf("%s r%0d last",  tag, r), 32'(out_last),  32'(last));
    check($sformatf("%s r%0d busy",  tag, r), 32'(busy),      32'd1);
    check($sformatf("%s r%0d done",  tag, r), 32'(done),      32'd0);
  endtask

  task automatic expect_done(input string tag);
    check({tag, " done"},  32'(done),      32'd1);
    check({tag, " dvld"},  32'(out_valid), 32'd0);
    check({tag, " dbusy"}, 32'(busy),      32'd1);
    tick();
    check({tag, " idle done"}, 32'(done),      32'd0);
    check({tag, " idle busy"}, 32'(busy),      32'd0);
    check({tag, " idle vld"},  32'(out_valid), 32'd0);
  endtask

  // Leaves the bench at the negedge of cycle t+1
  task automatic start_drain(input logic [2:0] c);
    start = 1'b1;
    count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic drain_full(input string tag, input logic [2:0] c, input int n);
    start_drain(c);
    for (int r = 0; r < n; r++) begin
      expect_beat(tag, r, r == n - 1);
`ifdef KSORT_DRAIN_CLEAR_EN
      check($sformatf("%s r%0d clear", tag, r), 32'(clear_reg), 32'(r == 0));
`endif
      tick();
    end
    expect_done(tag);
  endtask

  initial begin
    ev = '{8'd3, 8'd5, 8'd9, 8'd12};
    ei = '{8'd7, 8'd2, 8'd0, 8'd4};
    rst_n     = 1'b0;
    start     = 1'b0;
    count     = 3'd0;
    out_ready = 1'b1;
    in_val    = ev;
    in_idx    = ei;

    tick();
    check("rst busy",  32'(busy),      32'd0);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst last",  32'(out_last),  32'd0);
    check("rst done",  32'(done),      32'd0);
    check("rst data",  32'(out_data),  32'd0);
    check("rst index", 32'(out_index), 32'd0);
    check("rst rank",  32'(out_rank),  32'd0);
    rst_n = 1'b1;
    tick();

    // Full drain with ready high
    drain_full("full", 3'd4, 4);

    // count=2 with backpressure for three cycles
    out_ready = 1'b0;
    start_drain(3'd2);
    expect_beat("bp t1", 0, 1'b0);
    tick();
    expect_beat("bp t2", 0, 1'b0);
    tick();
    expect_beat("bp t3", 0, 1'b0);
    tick();
    out_ready = 1'b1;
    expect_beat("bp t4", 0, 1'b0);
    tick();
    expect_beat("bp t5", 1, 1'b1);
    tick();
    expect_done("bp");

    // count=0: only a done pulse
    start_drain(3'd0);
    check("zero valid", 32'(out_valid), 32'd0);
`ifdef KSORT_DRAIN_CLEAR_EN
    check("zero clear", 32'(clear_reg), 32'd1);
`endif
    expect_done("zero");

    // count above K clamps
    drain_full("clamp", 3'd7, 4);

    // Input changes and a stray start during SEND are ignored
    start_drain(3'd4);
    for (int r = 0; r < 4; r++) begin
      expect_beat("frz", r, r == 3);
      if (r == 0) begin
        in_val = '{default: 8'hFF};
        start  = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    expect_done("frz");
    tick();
    check("frz no restart vld",  32'(out_valid), 32'd0);
    check("frz no restart busy", 32'(busy),      32'd0);
    in_val = ev;

    // Reset during rank 1 abandons the drain
    start_drain(3'd4);
    expect_beat("mrst", 0, 1'b0);
    tick();
    expect_beat("mrst", 1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("mrst valid", 32'(out_valid), 32'd0);
    check("mrst busy",  32'(busy),      32'd0);
    check("mrst data",  32'(out_data),  32'd0);
    check("mrst index", 32'(out_index), 32'd0);
    check("mrst rank",  32'(out_rank),  32'd0);
    tick();
    check("mrst done",  32'(done),      32'd0);
    rst_n = 1'b1;
    tick();
    check("mrst post done", 32'(done), 32'd0);
    drain_full("post", 3'd4, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
